flag_register_unit: RTL and testbench

- Architectural status-flag register (N, Z, C, V): the write side of the condition-evaluation path.
- Takes ALU flags from the execute stage and commits them under per-group write enables, gated by the instruction's condition result.
- Presents the committed flags, plus a same-cycle bypass, in the packed {C,N,V,Z} order the condition checker consumes.
- Holds one shadow copy for exception entry/return (save/restore).

---
 rtl/flag_register_unit_if.sv | 28 ++
 rtl/flag_register_unit.sv | 74 +++++++
 tb/tb_flag_register_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/flag_register_unit_if.sv
// Flag-unit bus: execute-stage flag inputs, save/restore requests and committed/bypassed flag outputs.
// Flag vectors are packed {C,N,V,Z}, MSB first.
interface flag_register_unit_if #(
  parameter int FLAG_W = 4
);
  logic [FLAG_W-1:0] alu_flags;
  logic [1:0]        flag_w;
  logic              cond_ex;
  logic              stall;
  logic              flush;
  logic              save_req;
  logic              restore_req;
  logic [FLAG_W-1:0] flags;
  logic [FLAG_W-1:0] flags_fwd;
  logic              carry_in;
  logic              shadow_valid;
  logic              restore_err;

  modport master (
    output alu_flags, flag_w, cond_ex, stall, flush, save_req, restore_req,
    input  flags, flags_fwd, carry_in, shadow_valid, restore_err
  );

  modport slave (
    input  alu_flags, flag_w, cond_ex, stall, flush, save_req, restore_req,
    output flags, flags_fwd, carry_in, shadow_valid, restore_err
  );
endinterface

// File: rtl/flag_register_unit.sv
// Architectural N/Z/C/V flag register with grouped write enables, same-cycle bypass
// and a single shadow copy used for exception entry/return.
module flag_register_unit #(
  parameter int                FLAG_W      = 4,
  parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  flag_register_unit_if.slave   bus
);

  localparam int C_BIT = 3;
  localparam int N_BIT = 2;
  localparam int V_BIT = 1;
  localparam int Z_BIT = 0;

  logic [FLAG_W-1:0] r_flags;
  logic [FLAG_W-1:0] r_shadow;
  logic              r_shadow_valid;
  logic              r_restore_err;

  logic              w_we;
  logic              w_save;
  logic              w_restore;
  logic              w_restore_empty;
  logic [FLAG_W-1:0] w_flags_wr;
  logic [FLAG_W-1:0] w_flags_next;

  assign w_we            = bus.cond_ex & ~bus.flush & ~bus.stall;
  assign w_save          = bus.save_req & ~bus.stall;
  assign w_restore       = bus.restore_req & r_shadow_valid & ~bus.stall;
  assign w_restore_empty = bus.restore_req & ~r_shadow_valid & ~bus.stall;

  // Normal write result, before any restore override; this is also what a save captures.
  always_comb begin
    w_flags_wr = r_flags;
    if (w_we && bus.flag_w[1]) begin
      w_flags_wr[N_BIT] = bus.alu_flags[N_BIT];
      w_flags_wr[Z_BIT] = bus.alu_flags[Z_BIT];
    end
    if (w_we && bus.flag_w[0]) begin
      w_flags_wr[C_BIT] = bus.alu_flags[C_BIT];
      w_flags_wr[V_BIT] = bus.alu_flags[V_BIT];
    end
  end

  assign w_flags_next = w_restore ? r_shadow : w_flags_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags        <= RESET_FLAGS;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_restore_err  <= 1'b0;
    end else begin
      r_flags       <= w_flags_next;
      r_restore_err <= w_restore_empty;
      // A save in the same cycle as a restore turns it into a swap, so save wins on valid.
      if (w_save) begin
        r_shadow       <= w_flags_wr;
        r_shadow_valid <= 1'b1;
      end else if (w_restore) begin
        r_shadow_valid <= 1'b0;
      end
    end
  end

  assign bus.flags        = r_flags;
  assign bus.flags_fwd    = w_flags_next;
  assign bus.carry_in     = r_flags[C_BIT];
  assign bus.shadow_valid = r_shadow_valid;
  assign bus.restore_err  = r_restore_err;

endmodule

// File: tb/tb_flag_register_unit.sv
// Table-driven bench for flag_register_unit; post-edge expectations go through a scoreboard queue.
module tb_flag_register_unit;

  typedef struct {
    logic [3:0] alu;
    logic [1:0] fw;
    logic       cond;
    logic       stall;
    logic       flush;
    logic       save;
    logic       rest;
    logic [3:0] exp_fwd;
    logic [3:0] exp_flags;
    logic       exp_sv;
    logic       exp_err;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] flags;
    logic       sv;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [3:0] cur_flags;
  vec_t vecs[$];
  exp_t sb[$];

  flag_register_unit_if u_if ();

  flag_register_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] alu, input logic [1:0] fw,
                              input logic cond, input logic stall, input logic flush,
                              input logic save, input logic rest,
                              input logic [3:0] exp_fwd, input logic [3:0] exp_flags,
                              input logic exp_sv, input logic exp_err);
    vec_t v;
    v.alu = alu; v.fw = fw; v.cond = cond; v.stall = stall; v.flush = flush;
    v.save = save; v.rest = rest; v.exp_fwd = exp_fwd; v.exp_flags = exp_flags;
    v.exp_sv = exp_sv; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    u_if.alu_flags   = v.alu;
    u_if.flag_w      = v.fw;
    u_if.cond_ex     = v.cond;
    u_if.stall       = v.stall;
    u_if.flush       = v.flush;
    u_if.save_req    = v.save;
    u_if.restore_req = v.rest;
  endtask

  // Drive at negedge, check bypass/carry before the edge, scoreboard the registered results after it.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    drive(v);
    #1;
    check($sformatf("v%0d flags_fwd", idx), u_if.flags_fwd, v.exp_fwd);
    check($sformatf("v%0d carry_in", idx), {3'b000, u_if.carry_in}, {3'b000, cur_flags[3]});
    e.idx = idx; e.flags = v.exp_flags; e.sv = v.exp_sv; e.err = v.exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL v%0d scoreboard: got empty want entry", idx);
    end else begin
      got = sb.pop_front();
      check($sformatf("v%0d flags", got.idx), u_if.flags, got.flags);
      check($sformatf("v%0d shadow_valid", got.idx), {3'b000, u_if.shadow_valid}, {3'b000, got.sv});
      check($sformatf("v%0d restore_err", got.idx), {3'b000, u_if.restore_err}, {3'b000, got.err});
      cur_flags = got.flags;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cur_flags = 4'b0000;

    //            alu     fw    c  st fl sv rs  fwd      flags    sv err
    // reset release write
    vecs.push_back(mk(4'b1010, 2'b11, 1, 0, 0, 0, 0, 4'b1010, 4'b1010, 0, 0)); // 0
    // group masks and condition gating
    vecs.push_back(mk(4'b0000, 2'b11, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0)); // 1
    vecs.push_back(mk(4'b1111, 2'b10, 1, 0, 0, 0, 0, 4'b0101, 4'b0101, 0, 0)); // 2
    vecs.push_back(mk(4'b1111, 2'b01, 1, 0, 0, 0, 0, 4'b1111, 4'b1111, 0, 0)); // 3
    vecs.push_back(mk(4'b0000, 2'b11, 0, 0, 0, 0, 0, 4'b1111, 4'b1111, 0, 0)); // 4
    // stall / flush
    vecs.push_back(mk(4'b0011, 2'b11, 1, 0, 0, 0, 0, 4'b0011, 4'b0011, 0, 0)); // 5
    vecs.push_back(mk(4'b1100, 2'b11, 1, 1, 0, 0, 0, 4'b0011, 4'b0011, 0, 0)); // 6
    vecs.push_back(mk(4'b1100, 2'b11, 1, 0, 1, 0, 0, 4'b0011, 4'b0011, 0, 0)); // 7
    vecs.push_back(mk(4'b1100, 2'b11, 1, 0, 0, 0, 0, 4'b1100, 4'b1100, 0, 0)); // 8
    // save with same-cycle write, restore, restore on empty
    vecs.push_back(mk(4'b0110, 2'b11, 1, 0, 0, 0, 0, 4'b0110, 4'b0110, 0, 0)); // 9
    vecs.push_back(mk(4'b1001, 2'b11, 1, 0, 0, 1, 0, 4'b1001, 4'b1001, 1, 0)); // 10
    vecs.push_back(mk(4'b0000, 2'b11, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0)); // 11
    vecs.push_back(mk(4'b0000, 2'b11, 0, 0, 0, 0, 1, 4'b1001, 4'b1001, 0, 0)); // 12
    vecs.push_back(mk(4'b0000, 2'b11, 0, 0, 0, 0, 1, 4'b1001, 4'b1001, 0, 1)); // 13
    vecs.push_back(mk(4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b1001, 4'b1001, 0, 0)); // 14
    // swap and restore priority
    vecs.push_back(mk(4'b1100, 2'b11, 1, 0, 0, 1, 0, 4'b1100, 4'b1100, 1, 0)); // 15
    vecs.push_back(mk(4'b0011, 2'b11, 1, 0, 0, 0, 0, 4'b0011, 4'b0011, 1, 0)); // 16
    vecs.push_back(mk(4'b0000, 2'b00, 0, 0, 0, 1, 1, 4'b1100, 4'b1100, 1, 0)); // 17
    vecs.push_back(mk(4'b1111, 2'b11, 1, 0, 0, 0, 1, 4'b0011, 4'b0011, 0, 0)); // 18
    // empty restore still lets the write through
    vecs.push_back(mk(4'b0101, 2'b11, 1, 0, 0, 0, 1, 4'b0101, 4'b0101, 0, 1)); // 19
    // stall swallows requests and suppresses restore_err
    vecs.push_back(mk(4'b1111, 2'b11, 1, 1, 0, 1, 1, 4'b0101, 4'b0101, 0, 0)); // 20
    // flush blocks write but save still acts
    vecs.push_back(mk(4'b1010, 2'b11, 1, 0, 1, 1, 0, 4'b0101, 4'b0101, 1, 0)); // 21
    vecs.push_back(mk(4'b0000, 2'b11, 1, 1, 0, 0, 1, 4'b0101, 4'b0101, 1, 0)); // 22
    vecs.push_back(mk(4'b0000, 2'b11, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0)); // 23
    vecs.push_back(mk(4'b0000, 2'b00, 0, 0, 0, 0, 1, 4'b0101, 4'b0101, 0, 0)); // 24
    // carry comes from registered flags only
    vecs.push_back(mk(4'b1000, 2'b01, 1, 0, 0, 0, 0, 4'b1101, 4'b1101, 0, 0)); // 25
    vecs.push_back(mk(4'b0000, 2'b01, 1, 0, 0, 0, 0, 4'b0101, 4'b0101, 0, 0)); // 26
    vecs.push_back(mk(4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0101, 4'b0101, 0, 0)); // 27
    // save while valid overwrites the shadow
    vecs.push_back(mk(4'b1111, 2'b11, 1, 0, 0, 1, 0, 4'b1111, 4'b1111, 1, 0)); // 28
    vecs.push_back(mk(4'b0000, 2'b11, 1, 0, 0, 1, 0, 4'b0000, 4'b0000, 1, 0)); // 29
    vecs.push_back(mk(4'b1010, 2'b11, 1, 0, 0, 0, 0, 4'b1010, 4'b1010, 1, 0)); // 30
    vecs.push_back(mk(4'b0000, 2'b00, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0)); // 31

    drive(mk(4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", u_if.flags, 4'b0000);
    check("reset shadow_valid", {3'b000, u_if.shadow_valid}, 4'b0000);
    check("reset restore_err", {3'b000, u_if.restore_err}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand sequence: load 1111 and a valid shadow, then assert reset mid-cycle.
    apply(100, mk(4'b1111, 2'b11, 1, 0, 0, 1, 0, 4'b1111, 4'b1111, 1, 0));
    @(negedge clk);
    drive(mk(4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset flags", u_if.flags, 4'b0000);
    check("async reset shadow_valid", {3'b000, u_if.shadow_valid}, 4'b0000);
    check("async reset flags_fwd", u_if.flags_fwd, 4'b0000);
    cur_flags = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Shadow was cleared by reset: a restore must report empty.
    apply(101, mk(4'b0000, 2'b00, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
